// File: rtl/hls_deadlock_monitor_gen_if.sv
// Handshake bundle between a deadlock monitor and the logic that feeds/observes it.
interface hls_deadlock_monitor_gen_if #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1
);
  logic [NUM_AXIS-1:0]   axis_block_sigs;
  logic [NUM_INST-1:0]   inst_idle_sigs;
  logic [NUM_INST-1:0]   inst_block_sigs;
  logic                  clear;
  logic [2*NUM_AXIS-1:0] axis_block_info;
  logic [NUM_INST-1:0]   inst_block_info;
  logic                  block;
  logic [15:0]           event_count;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  axis_block_info, inst_block_info, block, event_count
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output axis_block_info, inst_block_info, block, event_count
  );
endinterface

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor: flags a persistent stall on AXIS channels or sub-instances,
// reports per-source block codes and counts detections (saturating).
module hls_deadlock_monitor_gen #(
  parameter int NUM_AXIS       = 2,
  parameter int NUM_INST       = 1,
  parameter int PERSIST_CYCLES = 1,
  parameter int STICKY         = 0
) (
  input logic                        clock,
  input logic                        reset,
  hls_deadlock_monitor_gen_if.slave  mon
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_PENDING = 2'd1;
  localparam logic [1:0]  ST_BLOCKED = 2'd2;
  localparam logic [15:0] PERSIST_W  = 16'(PERSIST_CYCLES);

  logic [1:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [2*NUM_AXIS-1:0] ainfo_q, ainfo_d, acode_s, axis_info_q, axis_info_d;
  logic [NUM_INST-1:0]   iinfo_q, iinfo_d, icode_s, inst_info_q, inst_info_d;
  logic                  block_q, block_d;
  logic [15:0]           event_count_q, event_count_d;
  logic                  cand_s;
  logic                  enter_s;
  logic                  accumulate_s;

  // Per-source block codes: even channels report 2'b10, odd channels 2'b01.
  always_comb begin
    acode_s = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      if (mon.axis_block_sigs[i]) begin
        acode_s[2*i +: 2] = (i % 2 == 0) ? 2'b10 : 2'b01;
      end else begin
        acode_s[2*i +: 2] = 2'b00;
      end
    end
    icode_s = mon.inst_block_sigs & ~mon.inst_idle_sigs;
    cand_s  = (|mon.axis_block_sigs) | (|icode_s);
  end

  // Persistence FSM, info capture and detection counter next-state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    event_count_d = event_count_q;
    accumulate_s  = (STICKY != 0) && (state_q == ST_BLOCKED);
    if (accumulate_s) begin
      ainfo_d = ainfo_q | acode_s;
      iinfo_d = iinfo_q | icode_s;
    end else begin
      ainfo_d = acode_s;
      iinfo_d = icode_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (cand_s && (PERSIST_CYCLES == 1)) begin
          state_d = ST_BLOCKED;
          cnt_d   = 16'd0;
        end else if (cand_s) begin
          state_d = ST_PENDING;
          cnt_d   = 16'd1;
        end else begin
          cnt_d   = 16'd0;
        end
      end
      ST_PENDING: begin
        if (!cand_s) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q + 16'd1 == PERSIST_W) begin
          state_d = ST_BLOCKED;
          cnt_d   = 16'd0;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_BLOCKED: begin
        cnt_d = 16'd0;
        if ((STICKY == 0) && !cand_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BLOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // A clear pulse wins over any simultaneous stall indication.
    if (mon.clear) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
      ainfo_d = '0;
      iinfo_d = '0;
    end else begin
      state_d = state_d;
    end

    enter_s = (state_d == ST_BLOCKED) && (state_q != ST_BLOCKED);
    if (enter_s && (event_count_q != 16'hFFFF)) begin
      event_count_d = event_count_q + 16'd1;
    end else begin
      event_count_d = event_count_q;
    end

    block_d = (state_d == ST_BLOCKED);
    if (block_d) begin
      axis_info_d = ainfo_d;
      inst_info_d = iinfo_d;
    end else begin
      axis_info_d = '0;
      inst_info_d = '0;
    end
  end

  // State and output registers; reset overrides clear and stall inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      ainfo_q       <= '0;
      iinfo_q       <= '0;
      axis_info_q   <= '0;
      inst_info_q   <= '0;
      block_q       <= 1'b0;
      event_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ainfo_q       <= ainfo_d;
      iinfo_q       <= iinfo_d;
      axis_info_q   <= axis_info_d;
      inst_info_q   <= inst_info_d;
      block_q       <= block_d;
      event_count_q <= event_count_d;
    end
  end

  assign mon.block           = block_q;
  assign mon.axis_block_info = axis_info_q;
  assign mon.inst_block_info = inst_info_q;
  assign mon.event_count     = event_count_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Directed plus randomized checks of four monitor configurations against a
// behavioural run-length model.
module tb_hls_deadlock_monitor_gen;

  typedef struct {
    int          run;
    bit          blk;
    logic [63:0] ai;
    logic [31:0] ii;
    int          cnt;
  } mst_t;

  logic        clock = 1'b0;
  logic [3:0]  rst;
  logic [3:0]  clr;
  logic [31:0] ab  [4];
  logic [31:0] idl [4];
  logic [31:0] ib  [4];
  mst_t        ms  [4];
  int          na_c [4] = '{2, 2, 4, 2};
  int          ni_c [4] = '{1, 2, 2, 1};
  int          pp_c [4] = '{1, 4, 1, 1};
  bit          st_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int          nvec = 0;
  int          nerr = 0;

  always #5 clock = ~clock;

  hls_deadlock_monitor_gen_if #(.NUM_AXIS(2), .NUM_INST(1)) if0 ();
  hls_deadlock_monitor_gen_if #(.NUM_AXIS(2), .NUM_INST(2)) if1 ();
  hls_deadlock_monitor_gen_if #(.NUM_AXIS(4), .NUM_INST(2)) if2 ();
  hls_deadlock_monitor_gen_if #(.NUM_AXIS(2), .NUM_INST(1)) if3 ();

  hls_deadlock_monitor_gen #(.NUM_AXIS(2), .NUM_INST(1), .PERSIST_CYCLES(1), .STICKY(0))
    dut0 (.clock(clock), .reset(rst[0]), .mon(if0));
  hls_deadlock_monitor_gen #(.NUM_AXIS(2), .NUM_INST(2), .PERSIST_CYCLES(4), .STICKY(0))
    dut1 (.clock(clock), .reset(rst[1]), .mon(if1));
  hls_deadlock_monitor_gen #(.NUM_AXIS(4), .NUM_INST(2), .PERSIST_CYCLES(1), .STICKY(0))
    dut2 (.clock(clock), .reset(rst[2]), .mon(if2));
  hls_deadlock_monitor_gen #(.NUM_AXIS(2), .NUM_INST(1), .PERSIST_CYCLES(1), .STICKY(1))
    dut3 (.clock(clock), .reset(rst[3]), .mon(if3));

  assign if0.axis_block_sigs = ab[0][1:0];
  assign if0.inst_idle_sigs  = idl[0][0:0];
  assign if0.inst_block_sigs = ib[0][0:0];
  assign if0.clear           = clr[0];
  assign if1.axis_block_sigs = ab[1][1:0];
  assign if1.inst_idle_sigs  = idl[1][1:0];
  assign if1.inst_block_sigs = ib[1][1:0];
  assign if1.clear           = clr[1];
  assign if2.axis_block_sigs = ab[2][3:0];
  assign if2.inst_idle_sigs  = idl[2][1:0];
  assign if2.inst_block_sigs = ib[2][1:0];
  assign if2.clear           = clr[2];
  assign if3.axis_block_sigs = ab[3][1:0];
  assign if3.inst_idle_sigs  = idl[3][0:0];
  assign if3.inst_block_sigs = ib[3][0:0];
  assign if3.clear           = clr[3];

  // Reference: count consecutive stalled edges; a detection fires once the run reaches P.
  function automatic mst_t mstep(mst_t s, int k, logic [31:0] a, logic [31:0] id,
                                 logic [31:0] b, bit c, bit r);
    mst_t        n;
    logic [63:0] code;
    logic [31:0] icode;
    bit          cand;
    n     = s;
    code  = 64'd0;
    icode = 32'd0;
    cand  = 1'b0;
    for (int i = 0; i < na_c[k]; i++) begin
      if (a[i]) begin
        cand = 1'b1;
        code = code | (64'((i % 2 == 0) ? 2 : 1) << (2 * i));
      end
    end
    for (int j = 0; j < ni_c[k]; j++) begin
      if (b[j] && !id[j]) begin
        cand     = 1'b1;
        icode[j] = 1'b1;
      end
    end
    if (r) begin
      n.run = 0; n.blk = 1'b0; n.ai = 64'd0; n.ii = 32'd0; n.cnt = 0;
      return n;
    end
    if (c) begin
      n.run = 0; n.blk = 1'b0; n.ai = 64'd0; n.ii = 32'd0;
      return n;
    end
    if (s.blk && st_c[k]) begin
      n.ai = s.ai | code;
      n.ii = s.ii | icode;
    end else begin
      n.ai = code;
      n.ii = icode;
    end
    if (s.blk) begin
      n.blk = st_c[k] ? 1'b1 : cand;
      n.run = 0;
    end else if (cand) begin
      n.run = s.run + 1;
      if (n.run >= pp_c[k]) begin
        n.blk = 1'b1;
        n.run = 0;
        n.cnt = (s.cnt < 65535) ? s.cnt + 1 : s.cnt;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(int k, logic b, logic [63:0] ai, logic [31:0] ii, logic [15:0] ec);
    chk($sformatf("d%0d.block", k), 64'(b), 64'(ms[k].blk));
    chk($sformatf("d%0d.axis_info", k), ai, ms[k].blk ? ms[k].ai : 64'd0);
    chk($sformatf("d%0d.inst_info", k), 64'(ii), 64'(ms[k].blk ? ms[k].ii : 32'd0));
    chk($sformatf("d%0d.event_count", k), 64'(ec), 64'(ms[k].cnt));
  endtask

  task automatic step();
    @(posedge clock);
    for (int k = 0; k < 4; k++) begin
      ms[k] = mstep(ms[k], k, ab[k], idl[k], ib[k], clr[k], rst[k]);
    end
    @(negedge clock);
    chk_dut(0, if0.block, 64'(if0.axis_block_info), 32'(if0.inst_block_info), if0.event_count);
    chk_dut(1, if1.block, 64'(if1.axis_block_info), 32'(if1.inst_block_info), if1.event_count);
    chk_dut(2, if2.block, 64'(if2.axis_block_info), 32'(if2.inst_block_info), if2.event_count);
    chk_dut(3, if3.block, 64'(if3.axis_block_info), 32'(if3.inst_block_info), if3.event_count);
  endtask

  task automatic quiet();
    for (int k = 0; k < 4; k++) begin
      ab[k] = 32'd0; idl[k] = 32'd0; ib[k] = 32'd0;
    end
    clr = 4'd0;
    rst = 4'd0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      ms[k].run = 0; ms[k].blk = 1'b0; ms[k].ai = 64'd0; ms[k].ii = 32'd0; ms[k].cnt = 0;
    end
    quiet();
    rst = 4'hF;
    @(negedge clock);
    step();
    step();
    chk("reset.block", 64'(if0.block), 64'd0);
    rst = 4'h0;

    // Single-cycle stall on channel 0, default configuration.
    ab[0] = 32'b01;
    step();
    chk("d0.pulse.block", 64'(if0.block), 64'd1);
    chk("d0.pulse.info", 64'(if0.axis_block_info), 64'b0010);
    chk("d0.pulse.count", 64'(if0.event_count), 64'd1);
    ab[0] = 32'd0;
    step();
    chk("d0.release.block", 64'(if0.block), 64'd0);
    chk("d0.release.info", 64'(if0.axis_block_info), 64'd0);

    // Persistence of four with a one-cycle gap.
    ab[1] = 32'b01;
    repeat (3) step();
    ab[1] = 32'd0;
    step();
    ab[1] = 32'b01;
    repeat (3) step();
    chk("d1.persist3.block", 64'(if1.block), 64'd0);
    step();
    chk("d1.persist4.block", 64'(if1.block), 64'd1);
    chk("d1.persist4.count", 64'(if1.event_count), 64'd1);
    ab[1] = 32'd0;
    step();

    // Four channels, odd ones stalled.
    ab[2] = 32'b1010;
    step();
    chk("d2.odd.block", 64'(if2.block), 64'd1);
    chk("d2.odd.info", 64'(if2.axis_block_info), 64'b01_00_01_00);
    ab[2] = 32'd0;
    step();

    // Sticky accumulation then clear.
    ab[3] = 32'b01;
    step();
    ab[3] = 32'b10;
    step();
    ab[3] = 32'd0;
    step();
    chk("d3.sticky.block", 64'(if3.block), 64'd1);
    chk("d3.sticky.info", 64'(if3.axis_block_info), 64'b0110);
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    chk("d3.clear.block", 64'(if3.block), 64'd0);
    chk("d3.clear.info", 64'(if3.axis_block_info), 64'd0);
    ab[3] = 32'b01;
    clr[3] = 1'b1;
    step();
    chk("d3.clear_prio.block", 64'(if3.block), 64'd0);
    quiet();
    step();

    // Instance blocking qualified by idle.
    ib[1] = 32'b11; idl[1] = 32'b01;
    repeat (4) step();
    chk("d1.inst.block", 64'(if1.block), 64'd1);
    chk("d1.inst.info", 64'(if1.inst_block_info), 64'b10);
    idl[1] = 32'b11;
    repeat (5) step();
    chk("d1.idle.block", 64'(if1.block), 64'd0);
    chk("d1.idle.count", 64'(if1.event_count), 64'd2);
    quiet();

    // Reset mid-PENDING and while BLOCKED.
    ab[1] = 32'b01;
    repeat (2) step();
    rst[1] = 1'b1;
    step();
    chk("d1.rst_pend.count", 64'(if1.event_count), 64'd0);
    ab[0] = 32'b01;
    rst[1] = 1'b0;
    ab[1] = 32'd0;
    step();
    rst[0] = 1'b1;
    clr[0] = 1'b1;
    step();
    chk("d0.rst_blk.block", 64'(if0.block), 64'd0);
    chk("d0.rst_blk.count", 64'(if0.event_count), 64'd0);
    quiet();
    step();

    // Counter saturation.
    force dut0.event_count_q = 16'hFFFE;
    release dut0.event_count_q;
    ms[0].cnt = 65534;
    ab[0] = 32'b01;
    step();
    chk("d0.sat1.count", 64'(if0.event_count), 64'hFFFF);
    ab[0] = 32'd0;
    step();
    ab[0] = 32'b01;
    step();
    chk("d0.sat2.count", 64'(if0.event_count), 64'hFFFF);
    quiet();
    step();

    // Randomized traffic on all configurations.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        ab[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        idl[k] = 32'($urandom);
        ib[k]  = 32'($urandom);
        clr[k] = ($urandom_range(0, 15) == 0);
        rst[k] = ($urandom_range(0, 63) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_monitor_gen.md
HLS_DEADLOCK_MONITOR_GEN -- requirements
Module: hls_deadlock_monitor_gen

Interface
REQ-001 SHALL have parameter NUM_AXIS, default 2: number of monitored AXIS block signals, range 1..32.
REQ-002 SHALL have parameter NUM_INST, default 1: number of monitored sub-instances, range 1..32.
REQ-003 SHALL have parameter PERSIST_CYCLES, default 1: consecutive sampled cycles of blocking required before `block` asserts, range 1..65535.
REQ-004 SHALL have parameter STICKY, default 0: 0 = live report, 1 = latched report until `clear`.
REQ-005 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port axis_block_sigs, input, NUM_AXIS: per-channel AXIS stall indication.
REQ-008 SHALL have port inst_idle_sigs, input, NUM_INST: per-instance idle.
REQ-009 SHALL have port inst_block_sigs, input, NUM_INST: per-instance blocked.
REQ-010 SHALL have port clear, input, 1: single-cycle pulse that releases a latched report.
REQ-011 SHALL have port axis_block_info, output, 2*NUM_AXIS: per-channel 2-bit block code.
REQ-012 SHALL have port inst_block_info, output, NUM_INST: per-instance block flag.
REQ-013 SHALL have port block, output, 1: deadlock detected.
REQ-014 SHALL have port event_count, output, 16: number of deadlock detections, saturating.

Function
REQ-015 SHALL compute combinational cand = (OR of axis_block_sigs) OR (OR of inst_block_sigs AND NOT inst_idle_sigs).
REQ-016 SHALL implement FSM states IDLE, PENDING and BLOCKED, plus a 16-bit persistence counter.
REQ-017 IDLE: if cand=1 and PERSIST_CYCLES=1, SHALL go to BLOCKED; if cand=1 and PERSIST_CYCLES>1, SHALL go to PENDING with counter=1; otherwise SHALL stay in IDLE with counter=0.
REQ-018 PENDING: if cand=0, SHALL go to IDLE with counter=0; if cand=1 and counter+1=PERSIST_CYCLES, SHALL go to BLOCKED; otherwise SHALL increment the counter.
REQ-019 BLOCKED, STICKY=0: SHALL go to IDLE on the first edge sampling cand=0.
REQ-020 BLOCKED, STICKY=1: SHALL stay in BLOCKED regardless of cand until clear=1.
REQ-021 clear=1 SHALL force IDLE, zero the counter and zero the info registers, in either mode and from any state; clear SHALL take priority over a simultaneous cand=1.
REQ-022 `block` SHALL be registered and SHALL equal 1 exactly when the FSM is in BLOCKED.
REQ-023 Consequence of REQ-017/022: `block` first asserts on edge N, where N is the PERSIST_CYCLES-th consecutive edge sampling cand=1; with PERSIST_CYCLES=1 this is one cycle of latency.
REQ-024 Internal register ainfo[2i+1:2i] SHALL be loaded each edge with 2'b10 (i even) or 2'b01 (i odd) if axis_block_sigs[i]=1, otherwise 2'b00.
REQ-025 Internal register iinfo[j] SHALL be loaded each edge with inst_block_sigs[j] AND NOT inst_idle_sigs[j].
REQ-026 When STICKY=1 and the FSM is in BLOCKED, info registers SHALL OR-accumulate the new codes instead of being overwritten.
REQ-027 axis_block_info and inst_block_info SHALL equal their info registers when block=1, and all-zero otherwise.
REQ-028 event_count SHALL increment by 1 on each transition into BLOCKED and SHALL saturate at 16'hFFFF.
REQ-029 event_count SHALL NOT be cleared by `clear`.
REQ-030 A cand=0 gap of even one cycle in PENDING SHALL restart persistence from zero.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, counter=0, info registers=0, block=0 and event_count=0, from any state including mid-PENDING or BLOCKED.
REQ-032 reset SHALL have priority over clear and cand.
REQ-033 All outputs SHALL be 0 in the cycle after reset.

Verification
REQ-034 Defaults; axis_block_sigs=2'b01 for 1 cycle -> next cycle block=1, axis_block_info=4'b0010, event_count=1; the cycle after that, block=0 and axis_block_info=0.
REQ-035 PERSIST_CYCLES=4; cand high 3 cycles, low 1 cycle, high 4 cycles -> block asserts only after the 4th consecutive high edge; event_count=1.
REQ-036 NUM_AXIS=4; axis_block_sigs=4'b1010 held -> axis_block_info=8'b01_00_01_00 while block=1.
REQ-037 STICKY=1; ch0 stalls, then ch1 stalls, then both release -> block stays 1 with axis_block_info=4'b0110; clear pulse -> next cycle block=0 and info=0.
REQ-038 NUM_INST=2; inst_block_sigs=2'b11 with inst_idle_sigs=2'b01 -> inst_block_info=2'b10, block=1; with idle=2'b11 -> no detection.
REQ-039 Reset asserted mid-PENDING and in BLOCKED -> all outputs 0 on the next cycle; forcing event_count to 16'hFFFF and applying a further detection -> event_count remains 16'hFFFF.
